// File: rtl/uart_rx_deser.sv
// UART 8N1 receive engine: 2-flop rx synchronizer, free-running 16x
// oversample tick, start/data/stop/break FSM and a one-deep holding register
// with overrun and frame-error reporting.
module uart_rx_deser #(
    parameter int NBITS   = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             rd_en,
    output logic [NBITS-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             overrun
);

    localparam int NW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [DVSR_W-1:0] TICK_LAST = DVSR_W'(DVSR - 1);
    localparam logic [3:0]        STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [NW-1:0]     BIT_LAST  = NW'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q, rx_s_d;
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic              tick;
    state_t            state_q, state_d;
    logic [3:0]        s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [NBITS-1:0]  shreg_q, shreg_d;
    logic              done, stop_bad;
    logic [NBITS-1:0]  rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    // Synchronizer inputs and free-running tick counter (never realigned to the start edge)
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        tick      = (cnt_q == TICK_LAST);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
    end

    // All state registers; the sync flops reset to the idle line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: sample mid start bit, then every 16 ticks for data, then the stop bit
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        s_d = '0;
                        n_d = '0;
                        // a start bit that is high again at mid-bit was a glitch
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        shreg_d = {rx_s_q, shreg_q[NBITS-1:1]};
                        s_d     = '0;
                        if (n_q == BIT_LAST) state_d = STOP;
                        else                 n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = '0;
                        // a low stop bit parks in BRK so a held-low line reports once
                        state_d = rx_s_q ? IDLE : BRK;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            BRK: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: frame completion strobes at the stop-sample tick
    always_comb begin
        done     = (state_q == STOP) && tick && (s_q == STOP_LAST) &&  rx_s_q;
        stop_bad = (state_q == STOP) && tick && (s_q == STOP_LAST) && !rx_s_q;
    end

    // Holding register: load, drop-with-overrun, or read; a read in the completion clk keeps valid
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = stop_bad;
        if (done) begin
            if (!rx_valid_q || rd_en) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rd_en) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser at DVSR=4 (one bit = 64 clk). Frames are driven
// bit-serially; a frame-level model of the holding register predicts outputs.
module tb_uart_rx_deser;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx_deser #(.NBITS(8), .SB_TICK(16), .DVSR(4), .DVSR_W(2)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0, fe_run = 0, fe_maxrun = 0;
    int rise_cyc = -1000;
    logic prev_v = 1'b0;
    int frame_start = 0;
    int c0 = 0, lat = 0;

    // frame-level model of the holding register
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovr   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // frame_err pulse counting / width and rx_valid rise time
    always @(negedge clk) begin
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_run <= fe_run + 1;
            if (fe_run + 1 > fe_maxrun) fe_maxrun <= fe_run + 1;
        end else begin
            fe_run <= 0;
        end
        if (rx_valid && !prev_v) rise_cyc <= cyc;
        prev_v <= rx_valid;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
    endtask

    task automatic model_complete(input logic [7:0] b, input logic rd);
        if (!m_valid || rd) begin
            m_data = b; m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic model_read();
        if (m_valid) begin
            m_valid = 1'b0; m_ovr = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits = 10);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            rx = fr[i];
            if (i == 0) frame_start = cyc;
            repeat (BIT - 1) @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        model_read();
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b exp 0", overrun); end
        reset = 1'b0;
        model_reset();
        idle(20);
    endtask

    task automatic test_basic();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1);
        model_complete(8'hA5, 1'b0);
        idle(5);
        c0  = frame_start;
        lat = rise_cyc - frame_start;
        checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL basic_valid: got %b exp %b", rx_valid, m_valid); end
        checks++; if (rx_data !== m_data) begin errors++; $display("FAIL basic_data: got %h exp %h", rx_data, m_data); end
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL basic_ovr: got %b exp %b", overrun, m_ovr); end
        checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL basic_ferr: got %0d pulses exp 0", fe_cnt - fe0); end
        // 9.5 bits = 608 clk from the start edge, plus sync and tick-phase slack
        checks++; if (lat < 604 || lat > 616) begin errors++; $display("FAIL basic_latency: got %0d clk exp 604..616", lat); end
    endtask

    task automatic test_glitch();
        int fe0;
        do_read();
        fe0 = fe_cnt;
        @(posedge clk); #1 rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        idle(200);
        checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL glitch_valid: got %b exp %b", rx_valid, m_valid); end
        checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses exp 0", fe_cnt - fe0); end
        send_frame(8'h3C, 1'b1);
        model_complete(8'h3C, 1'b0);
        idle(5);
        checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL glitch_after_valid: got %b exp %b", rx_valid, m_valid); end
        checks++; if (rx_data !== m_data) begin errors++; $display("FAIL glitch_after_data: got %h exp %h", rx_data, m_data); end
    endtask

    task automatic test_frame_err();
        int fe0;
        do_read();
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (3 * BIT) @(posedge clk);
        #1;
        idle(100);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d pulses exp 1", fe_cnt - fe0); end
        checks++; if (fe_maxrun !== 1) begin errors++; $display("FAIL ferr_width: got %0d clk exp 1", fe_maxrun); end
        checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL ferr_valid: got %b exp %b", rx_valid, m_valid); end
        send_frame(8'h81, 1'b1);
        model_complete(8'h81, 1'b0);
        idle(5);
        checks++; if (rx_data !== m_data || rx_valid !== m_valid) begin
            errors++; $display("FAIL ferr_next: got %h/%b exp %h/%b", rx_data, rx_valid, m_data, m_valid);
        end
    endtask

    task automatic test_overrun();
        do_read();
        send_frame(8'h11, 1'b1);
        model_complete(8'h11, 1'b0);
        send_frame(8'h22, 1'b1);
        model_complete(8'h22, 1'b0);
        idle(5);
        checks++; if (rx_data !== m_data) begin errors++; $display("FAIL ovr_data: got %h exp %h", rx_data, m_data); end
        checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL ovr_valid: got %b exp %b", rx_valid, m_valid); end
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL ovr_flag: got %b exp %b", overrun, m_ovr); end
        do_read();
        #1;
        checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL ovr_read_valid: got %b exp %b", rx_valid, m_valid); end
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL ovr_read_flag: got %b exp %b", overrun, m_ovr); end
    endtask

    // rd_en lands on the completion clk, found from the tick phase measured in test_basic
    task automatic test_back_to_back();
        int target;
        logic drop;
        send_frame(8'h11, 1'b1);
        model_complete(8'h11, 1'b0);
        idle(5);
        while (((cyc + 1 - c0) % 4) != 0) begin
            @(posedge clk); #1;
        end
        target = cyc + 1 + lat;
        drop = 1'b0;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                while (cyc < target - 1) begin
                    @(posedge clk); #1;
                end
                rd_en = 1'b1;
                @(posedge clk); #1;
                rd_en = 1'b0;
            end
            begin
                repeat (660) begin
                    @(negedge clk);
                    if (!rx_valid) drop = 1'b1;
                end
            end
        join
        model_complete(8'h7E, 1'b1);
        idle(5);
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL coll_drop: rx_valid fell %b exp 0", drop); end
        checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL coll_valid: got %b exp %b", rx_valid, m_valid); end
        checks++; if (rx_data !== m_data) begin errors++; $display("FAIL coll_data: got %h exp %h", rx_data, m_data); end
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL coll_ovr: got %b exp %b", overrun, m_ovr); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_read();
            send_frame(b, 1'b1);
            model_complete(b, 1'b0);
            idle($urandom_range(1, 40));
            checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL rand%0d_valid: got %b exp %b", i, rx_valid, m_valid); end
            checks++; if (rx_data !== m_data) begin errors++; $display("FAIL rand%0d_data: got %h exp %h", i, rx_data, m_data); end
            checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rand%0d_ovr: got %b exp %b", i, overrun, m_ovr); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'hF0;
        send_frame(8'h12, 1'b1);
        model_complete(8'h12, 1'b0);
        send_frame(8'h34, 1'b1);
        model_complete(8'h34, 1'b0);
        idle(5);
        send_frame(b, 1'b1, 5);
        @(posedge clk); #1 rx = b[4];
        repeat (20) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b exp 0", overrun); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        idle(50);
        send_frame(8'hC3, 1'b1);
        model_complete(8'hC3, 1'b0);
        idle(5);
        checks++; if (rx_valid !== m_valid) begin errors++; $display("FAIL rst_after_valid: got %b exp %b", rx_valid, m_valid); end
        checks++; if (rx_data !== m_data) begin errors++; $display("FAIL rst_after_data: got %h exp %h", rx_data, m_data); end
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rst_after_ovr: got %b exp %b", overrun, m_ovr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
